// File: rtl/grayscaler_rx.sv
// RGB byte-stream receiver: buffers bytes in a 4-deep FIFO, assembles R,G,B,
// computes weighted luma and hands one grayscale pixel at a time downstream.
module grayscaler_rx #(
  parameter int N  = 2,
  parameter int M  = 2,
  parameter int WR = 77,
  parameter int WG = 150,
  parameter int WB = 29
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] data_in,
  input  logic       in_valid,
  output logic       pause,
  output logic [7:0] gray_out,
  output logic       gray_valid,
  input  logic       gray_ready,
  output logic       done,
  output logic       overflow
);

  localparam int PIX = N * M;
  localparam int PW  = $clog2(PIX + 1);
  localparam logic [PW-1:0] LAST_PIX = PW'(PIX - 1);
  localparam logic [15:0] WR16 = 16'(WR);
  localparam logic [15:0] WG16 = 16'(WG);
  localparam logic [15:0] WB16 = 16'(WB);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_COMPUTE,
    S_OUTPUT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [PW-1:0]   pix_q, pix_d;
  logic [7:0]      r_q, r_d, g_q, g_d, b_q, b_d;
  logic [7:0]      gray_q, gray_d;
  logic            ovf_q, ovf_d;

  logic [7:0]      fifo_mem [4];
  logic [1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]      count_q, count_d;
  logic            fifo_full, fifo_empty;
  logic            push, pop;
  logic [7:0]      fifo_rd;
  logic [15:0]     sum;

  assign fifo_full  = (count_q == 3'd4);
  assign fifo_empty = (count_q == 3'd0);
  assign fifo_rd    = fifo_mem[rd_ptr_q];
  assign sum        = WR16 * {8'h00, r_q} + WG16 * {8'h00, g_q} + WB16 * {8'h00, b_q};

  assign pause      = (count_q >= 3'd2);
  assign gray_out   = gray_q;
  assign gray_valid = (state_q == S_OUTPUT);
  assign done       = (state_q == S_DONE);
  assign overflow   = ovf_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pix_d   = pix_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    gray_d  = gray_q;
    pop     = 1'b0;
    // Input side runs independently of the pixel FSM, except while parked idle.
    push    = in_valid && !fifo_full && !(state_q == S_IDLE && !enable);
    ovf_d   = ovf_q | (in_valid && fifo_full);

    case (state_q)
      S_IDLE: begin
        idx_d = 2'd0;
        pix_d = '0;
        if (enable) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          case (idx_q)
            2'd0:    r_d = fifo_rd;
            2'd1:    g_d = fifo_rd;
            default: b_d = fifo_rd;
          endcase
          if (idx_q == 2'd2) begin
            idx_d   = 2'd0;
            state_d = S_COMPUTE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      S_COMPUTE: begin
        gray_d  = sum[15:8];
        state_d = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (gray_ready) begin
          pix_d   = pix_q + 1'b1;
          state_d = (pix_q == LAST_PIX) ? S_DONE : S_COLLECT;
        end
      end
      S_DONE: begin
        pix_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= 2'd0;
      pix_q    <= '0;
      r_q      <= 8'h00;
      g_q      <= 8'h00;
      b_q      <= 8'h00;
      gray_q   <= 8'h00;
      ovf_q    <= 1'b0;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pix_q    <= pix_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
      gray_q   <= gray_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: emptiness is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= data_in;
  end

endmodule

// File: tb/tb_grayscaler_rx.sv
// Directed bench for grayscaler_rx: hand-computed luma values, stall,
// overflow, mid-frame reset and enable-drop scenarios.
module tb_grayscaler_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       in_valid = 1'b0;
  logic       pause;
  logic [7:0] gray_out;
  logic       gray_valid;
  logic       gray_ready = 1'b0;
  logic       done;
  logic       overflow;

  grayscaler_rx #(.N(2), .M(2), .WR(77), .WG(150), .WB(29)) dut (
    .clk(clk), .rst(rst), .enable(enable), .data_in(data_in),
    .in_valid(in_valid), .pause(pause), .gray_out(gray_out),
    .gray_valid(gray_valid), .gray_ready(gray_ready), .done(done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_hs_cyc = -2;
  logic mem_on = 1'b0;
  logic pause_prev = 1'b0;
  logic [7:0] src[$];
  logic [7:0] got[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] got_at(input int i);
    if (i < got.size()) return got[i];
    return 8'hxx;
  endfunction

  // One clock; captures handshakes/done and, when mem_on, models a memory
  // that reacts to pause one cycle late.
  task automatic tick();
    logic       hs;
    logic [7:0] hs_val;
    hs     = gray_valid && gray_ready;
    hs_val = gray_out;
    @(posedge clk);
    #1;
    cyc++;
    if (hs) begin
      got.push_back(hs_val);
      last_hs_cyc = cyc;
      $display("cycle %0d: pixel accepted gray=%0d", cyc, hs_val);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      $display("cycle %0d: done pulse", cyc);
    end
    if (mem_on) begin
      if (src.size() > 0 && !pause_prev) begin
        in_valid = 1'b1;
        data_in  = src.pop_front();
      end else begin
        in_valid = 1'b0;
      end
    end
    pause_prev = pause;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; enable = 1'b0; gray_ready = 1'b0; mem_on = 1'b0;
    tick(); tick();
    rst = 1'b0;
    src.delete(); got.delete();
    done_cnt = 0; done_cyc = -1; last_hs_cyc = -2; pause_prev = 1'b0;
  endtask

  task automatic load_frame();
    src = '{8'd255, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd255,
            8'd100, 8'd150, 8'd200};
  endtask

  task automatic feed3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    in_valid = 1'b1; data_in = a; tick();
    data_in = b; tick();
    data_in = c; tick();
    in_valid = 1'b0;
  endtask

  logic [7:0] held;
  logic stable, saw_pause, saw_valid;

  initial begin
    // Reset state
    do_reset();
    chk("rst_gray_out", gray_out, 8'h00);
    chk("rst_gray_valid", gray_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_pause", pause, 1'b0);

    // White pixel and latency: B popped at 4th edge, valid after 5th
    enable = 1'b1; gray_ready = 1'b1;
    feed3(8'd255, 8'd255, 8'd255);
    tick();
    chk("white_valid_early", gray_valid, 1'b0);
    tick();
    chk("white_valid", gray_valid, 1'b1);
    chk("white_gray", gray_out, 8'hFF);
    gray_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", gray_valid, 1'b0);
    chk("midrst_gray", gray_out, 8'h00);

    // Four reference pixels, free-flowing
    do_reset();
    load_frame(); mem_on = 1'b1; enable = 1'b1; gray_ready = 1'b1;
    for (int k = 0; k < 300 && done_cnt == 0; k++) tick();
    for (int k = 0; k < 10; k++) tick();
    chk("frame_done_count", done_cnt, 1);
    chk("frame_npix", got.size(), 4);
    chk("frame_px0", got_at(0), 8'd76);
    chk("frame_px1", got_at(1), 8'd149);
    chk("frame_px2", got_at(2), 8'd28);
    chk("frame_px3", got_at(3), 8'd140);
    chk("frame_done_timing", done_cyc, last_hs_cyc);

    // Downstream stall of 10 cycles while memory keeps streaming
    do_reset();
    load_frame(); mem_on = 1'b1; enable = 1'b1; gray_ready = 1'b0;
    saw_pause = 1'b0;
    for (int k = 0; k < 50 && !gray_valid; k++) begin
      tick();
      if (pause) saw_pause = 1'b1;
    end
    chk("stall_valid", gray_valid, 1'b1);
    held = gray_out; stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (pause) saw_pause = 1'b1;
      if (gray_out !== held || gray_valid !== 1'b1) stable = 1'b0;
    end
    chk("stall_gray", held, 8'd76);
    chk("stall_stable", stable, 1'b1);
    chk("stall_pause_seen", saw_pause, 1'b1);
    chk("stall_overflow", overflow, 1'b0);
    gray_ready = 1'b1;
    for (int k = 0; k < 300 && done_cnt == 0; k++) tick();
    chk("stall_done", done_cnt, 1);
    chk("stall_px1", got_at(1), 8'd149);
    chk("stall_px2", got_at(2), 8'd28);
    chk("stall_px3", got_at(3), 8'd140);

    // Overflow: pause ignored while output is stalled
    do_reset();
    enable = 1'b1; gray_ready = 1'b0;
    feed3(8'd10, 8'd20, 8'd30);
    tick(); tick();
    chk("ovf_px0_gray", gray_out, 8'd18);
    in_valid = 1'b1; data_in = 8'd40; tick();
    data_in = 8'd50; tick();
    chk("ovf_pause2", pause, 1'b1);
    data_in = 8'd60; tick();
    data_in = 8'd70; tick();
    chk("ovf_full_no_flag", overflow, 1'b0);
    data_in = 8'd80; tick();
    chk("ovf_flag", overflow, 1'b1);
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("ovf_sticky", overflow, 1'b1);
    gray_ready = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    chk("ovf_px1_from_fifo", got_at(1), 8'd48);
    chk("ovf_sticky2", overflow, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("ovf_cleared", overflow, 1'b0);

    // Reset after 4 bytes, then fresh frame with enable dropped after pixel 0
    do_reset();
    enable = 1'b1;
    feed3(8'd255, 8'd0, 8'd0);
    in_valid = 1'b1; data_in = 8'd7; tick();
    in_valid = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    chk("r4_valid", gray_valid, 1'b0);
    chk("r4_pause", pause, 1'b0);
    chk("r4_gray", gray_out, 8'h00);
    chk("r4_done", done, 1'b0);
    chk("r4_ovf", overflow, 1'b0);
    load_frame(); mem_on = 1'b1; enable = 1'b1; gray_ready = 1'b1;
    for (int k = 0; k < 300 && done_cnt == 0; k++) begin
      tick();
      if (got.size() >= 1) enable = 1'b0;
    end
    chk("en_done", done_cnt, 1);
    chk("en_px0", got_at(0), 8'd76);
    chk("en_px3", got_at(3), 8'd140);
    src = '{8'd255, 8'd255, 8'd255};
    saw_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (gray_valid) saw_valid = 1'b1;
    end
    chk("en_idle_no_valid", saw_valid, 1'b0);
    chk("en_idle_done_once", done_cnt, 1);
    chk("en_idle_pause", pause, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/grayscaler_rx.md
GRAYSCALER_RX -- requirements
Module: grayscaler_rx

Interface
REQ-001 Parameter N, default 2: image height in pixels.
REQ-002 Parameter M, default 2: image width in pixels; a frame is N*M pixels, 3*N*M bytes in R,G,B order.
REQ-003 Parameters WR, WG, WB, defaults 77, 150, 29: 8-bit luma weights; WR+WG+WB SHALL equal 256.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  high starts or continues frame reception; low in IDLE keeps the block idle.
REQ-007 data_in  in  8  RGB byte from pixel memory.
REQ-008 in_valid  in  1  data_in carries a valid byte this cycle.
REQ-009 pause  out  1  back-pressure to pixel memory; high means "stop sending".
REQ-010 gray_out  out  8  grayscale pixel.
REQ-011 gray_valid  out  1  gray_out valid; held until accepted.
REQ-012 gray_ready  in  1  downstream accepts gray_out when gray_valid&gray_ready.
REQ-013 done  out  1  one-cycle pulse after the last pixel of a frame is accepted.
REQ-014 overflow  out  1  sticky flag: a byte arrived while the input FIFO was full.

Function
REQ-015 Input FIFO, depth 4 bytes: push when in_valid=1 and not full, in every state except IDLE-with-enable=0; simultaneous push and pop allowed.
REQ-016 pause SHALL equal (fifo_count >= 2), combinational from the registered count, giving 2 bytes of skid for the memory's one-cycle pause reaction.
REQ-017 A byte with in_valid=1 and FIFO full SHALL be dropped and set overflow=1; overflow clears only on rst.
REQ-018 States: IDLE, COLLECT, COMPUTE, OUTPUT, DONE.
REQ-019 IDLE: byte index and pixel counter held at 0; enable=1 -> COLLECT next cycle.
REQ-020 COLLECT: pop one byte per cycle when FIFO non-empty into R, G, B registers by byte index 0,1,2; after popping index 2 -> COMPUTE, byte index wraps to 0.
REQ-021 COMPUTE (exactly 1 cycle): sum = WR*R + WG*G + WB*B in 16 bits, gray_out <= sum[15:8] (truncate, no rounding) -> OUTPUT.
REQ-022 OUTPUT: gray_valid=1, gray_out stable; on gray_valid&gray_ready pixel counter increments; if it was pixel N*M-1 -> DONE, else -> COLLECT.
REQ-023 Latency: gray_valid rises 2 cycles after the cycle the B byte is popped.
REQ-024 DONE (1 cycle): done=1, pixel counter reset to 0 -> IDLE.
REQ-025 gray_valid=1 only in OUTPUT; done=1 only in DONE.
REQ-026 enable is sampled only in IDLE; deasserting it mid-frame does not abort the frame.
REQ-027 FIFO contents remaining at DONE are retained and used by the next frame.

Reset
REQ-028 rst=1 at any clock edge, including mid-frame: state IDLE, FIFO empty, byte index 0, pixel counter 0, R/G/B 0, gray_out 0x00, gray_valid 0, done 0, overflow 0, pause 0; rst takes priority over all other inputs.

Verification
REQ-029 Bytes (255,255,255) streamed, gray_ready=1 -> gray_out=0xFF, gray_valid 2 cycles after B pop.
REQ-030 Pixels (255,0,0),(0,255,0),(0,0,255),(100,150,200) with N=M=2 -> gray_out 76, 149, 28, 140; done pulses once, one cycle after the 4th handshake.
REQ-031 gray_ready=0 for 10 cycles while memory streams -> pause rises when count reaches 2, no byte lost, overflow stays 0, gray_out stable during stall.
REQ-032 in_valid forced high with pause ignored and gray_ready=0 -> FIFO fills to 4, next byte sets overflow=1, overflow persists until rst.
REQ-033 rst asserted after 4 bytes of a frame -> all outputs at reset values next cycle; a fresh frame afterward produces correct pixels from byte 0.
REQ-034 enable dropped after first pixel -> frame completes, done pulses, block then stays in IDLE.
